// File: rtl/tdc_readout_sched.sv
// TDC acquisition session control plus FIFO-to-UART packet serialiser.
// Define TDC_READOUT_CHECKSUM_EN to append an XOR checksum byte to every packet.
module tdc_readout_sched #(
  parameter int          DATA_W = 32,
  parameter int          CNT_W  = 16,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_acq,
  input  logic              stop_acq,
  input  logic [CNT_W-1:0]  n_hits,
  input  logic              tdc_done,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tdc_enable,
  output logic              fifo_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err_full,
  output logic [CNT_W-1:0]  word_count
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(NB + 2);
`ifdef TDC_READOUT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] NB_IDX   = IDX_W'(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_DRAIN} sess_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RD, R_LOAD, R_SEND} rd_state_t;

  sess_state_t       s_state;
  rd_state_t         r_state;
  logic [CNT_W-1:0]  hit_limit;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  hit_count_nxt;
  logic              hit_ok;
  logic              limit_hit;
  logic              session_start;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  byte_idx;
`ifdef TDC_READOUT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign session_start = (s_state == S_IDLE) && start_acq;
  assign hit_ok        = (s_state == S_ACQ) && tdc_done && !fifo_full;
  assign hit_count_nxt = hit_count + CNT_W'(hit_ok);
  // Compare against the post-increment count so tdc_enable drops on the edge after the last hit.
  assign limit_hit     = hit_ok && (hit_limit != '0) && (hit_count_nxt == hit_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state    <= S_IDLE;
      hit_limit  <= '0;
      hit_count  <= '0;
      tdc_enable <= 1'b0;
      busy       <= 1'b0;
      err_full   <= 1'b0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (start_acq) begin
            s_state    <= S_ACQ;
            hit_limit  <= n_hits;
            hit_count  <= '0;
            err_full   <= 1'b0;
            tdc_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_ACQ: begin
          hit_count <= hit_count_nxt;
          if (tdc_done && fifo_full) err_full <= 1'b1;
          if (stop_acq || limit_hit) begin
            s_state    <= S_DRAIN;
            tdc_enable <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (fifo_empty && (r_state == R_IDLE)) begin
            s_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      fifo_rd_en <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      shift_reg  <= '0;
      byte_idx   <= '0;
      word_count <= '0;
`ifdef TDC_READOUT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (session_start) word_count <= '0;
      case (r_state)
        R_IDLE: begin
          if ((s_state != S_IDLE) && !fifo_empty) begin
            r_state    <= R_RD;
            fifo_rd_en <= 1'b1;
          end
        end
        R_RD: begin
          fifo_rd_en <= 1'b0;
          r_state    <= R_LOAD;
        end
        R_LOAD: begin
          shift_reg <= fifo_data;
          byte_idx  <= '0;
          tx_data   <= HDR;
          tx_valid  <= 1'b1;
`ifdef TDC_READOUT_CHECKSUM_EN
          csum      <= HDR;
`endif
          r_state   <= R_SEND;
        end
        R_SEND: begin
          if (tx_ready) begin
            if (byte_idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              r_state  <= R_IDLE;
              if (word_count != '1) word_count <= word_count + CNT_W'(1);
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
`ifdef TDC_READOUT_CHECKSUM_EN
              if (byte_idx != '0) csum <= csum ^ tx_data;
              if (byte_idx == NB_IDX) begin
                tx_data <= csum ^ tx_data;
              end else
`endif
              begin
                tx_data   <= shift_reg[7:0];
                shift_reg <= shift_reg >> 8;
              end
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_readout_sched.sv
// Directed self-checking bench for tdc_readout_sched with a behavioural FIFO and byte sink.
module tb_tdc_readout_sched;

  localparam int         DATA_W = 32;
  localparam int         CNT_W  = 16;
  localparam logic [7:0] HDR    = 8'hA5;
`ifdef TDC_READOUT_CHECKSUM_EN
  localparam int PKT_LEN = DATA_W / 8 + 2;
`else
  localparam int PKT_LEN = DATA_W / 8 + 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start_acq;
  logic              stop_acq;
  logic [CNT_W-1:0]  n_hits;
  logic              tdc_done;
  logic              fifo_full;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              tdc_enable;
  logic              fifo_rd_en;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              err_full;
  logic [CNT_W-1:0]  word_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]        rx_q[$];
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] word_src;
  logic [DATA_W-1:0] wlist[5];

  tdc_readout_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W), .HDR(HDR)) dut (
    .clk(clk), .rst(rst), .start_acq(start_acq), .stop_acq(stop_acq),
    .n_hits(n_hits), .tdc_done(tdc_done), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .tdc_enable(tdc_enable),
    .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err_full(err_full), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Each accepted TDC hit writes word_src; reads return data one cycle later.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    if (tdc_done && !fifo_full) fifo_q.push_back(word_src);
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic d, input logic f);
    start_acq = s;
    stop_acq  = p;
    tdc_done  = d;
    fifo_full = f;
    tick();
    start_acq = 1'b0;
    stop_acq  = 1'b0;
    tdc_done  = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
      if (busy === 1'b0) checkOutput({tag, "_empty_at_idle"}, 32'(fifo_empty), 1);
    end
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic checkPacket(input string tag, input int base, input logic [DATA_W-1:0] w);
`ifdef TDC_READOUT_CHECKSUM_EN
    logic [7:0] cs = HDR;
`endif
    checkOutput({tag, "_hdr"}, 32'(rx_q[base]), 32'(HDR));
    for (int i = 0; i < DATA_W / 8; i++) begin
      checkOutput($sformatf("%s_b%0d", tag, i), 32'(rx_q[base + 1 + i]), 32'(w[8*i +: 8]));
`ifdef TDC_READOUT_CHECKSUM_EN
      cs ^= w[8*i +: 8];
`endif
    end
`ifdef TDC_READOUT_CHECKSUM_EN
    checkOutput({tag, "_cs"}, 32'(rx_q[base + DATA_W / 8 + 1]), 32'(cs));
`endif
  endtask

  initial begin
    int n;
    int vio;
    wlist = '{32'hA1B2C3D4, 32'h00000001, 32'hFFFFFFFF, 32'h5A5A0F0F, 32'h13579BDF};
    rst = 1'b1; start_acq = 1'b0; stop_acq = 1'b0; tdc_done = 1'b0;
    fifo_full = 1'b0; tx_ready = 1'b1; n_hits = '0; word_src = '0;
    tick();
    tick();
    checkOutput("rst_en", 32'(tdc_enable), 0);
    checkOutput("rst_rd", 32'(fifo_rd_en), 0);
    checkOutput("rst_valid", 32'(tx_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_err", 32'(err_full), 0);
    checkOutput("rst_data", 32'(tx_data), 0);
    checkOutput("rst_wc", 32'(word_count), 0);
    rst = 1'b0;
    tick();

    // Single word with a hit limit of one
    rx_q.delete();
    n_hits = 1;
    word_src = 32'h12345678;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_en", 32'(tdc_enable), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t1_en_drop", 32'(tdc_enable), 0);
    n = 0;
    while (fifo_rd_en !== 1'b1 && n < 10) begin tick(); n++; end
    checkOutput("t1_rd_seen", 32'(fifo_rd_en), 1);
    tick();
    checkOutput("t1_rd_width", 32'(fifo_rd_en), 0);
    tick();
    checkOutput("t1_first_valid", 32'(tx_valid), 1);
    checkOutput("t1_first_byte", 32'(tx_data), 32'(HDR));
    waitIdle("t1", 50);
    checkOutput("t1_len", 32'(rx_q.size()), PKT_LEN);
    checkPacket("t1", 0, 32'h12345678);
    checkOutput("t1_wc", 32'(word_count), 1);

    // Backpressure on the second data byte
    rx_q.delete();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    n = 0;
    while (!(tx_valid === 1'b1 && tx_data === 8'h56) && n < 30) begin tick(); n++; end
    tx_ready = 1'b0;
    checkOutput("t2_hold_data", 32'(tx_data), 32'h56);
    checkOutput("t2_hold_valid", 32'(tx_valid), 1);
    for (int i = 1; i < 7; i++) begin
      tick();
      checkOutput($sformatf("t2_hold_data_%0d", i), 32'(tx_data), 32'h56);
      checkOutput($sformatf("t2_hold_valid_%0d", i), 32'(tx_valid), 1);
    end
    tx_ready = 1'b1;
    waitIdle("t2", 50);
    checkOutput("t2_len", 32'(rx_q.size()), PKT_LEN);
    checkPacket("t2", 0, 32'h12345678);
    checkOutput("t2_wc", 32'(word_count), 1);

    // Unlimited session ended by stop_acq with a FIFO backlog
    rx_q.delete();
    n_hits = 0;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      word_src = wlist[i];
      applyStimulus(0, 0, 1, 0);
      tick();
    end
    checkOutput("t3_en_unlimited", 32'(tdc_enable), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t3_en_stop", 32'(tdc_enable), 0);
    checkOutput("t3_busy_drain", 32'(busy), 1);
    waitIdle("t3", 200);
    checkOutput("t3_len", 32'(rx_q.size()), 5 * PKT_LEN);
    for (int i = 0; i < 5; i++) checkPacket($sformatf("t3_p%0d", i), i * PKT_LEN, wlist[i]);
    checkOutput("t3_wc", 32'(word_count), 5);

    // Hit while FIFO full: flagged and not counted
    rx_q.delete();
    n_hits = 2;
    word_src = 32'hCAFEF00D;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("t4_err_set", 32'(err_full), 1);
    checkOutput("t4_en_after_full", 32'(tdc_enable), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t4_en_one_hit", 32'(tdc_enable), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t4_en_limit", 32'(tdc_enable), 0);
    waitIdle("t4", 100);
    checkOutput("t4_len", 32'(rx_q.size()), 2 * PKT_LEN);
    checkOutput("t4_wc", 32'(word_count), 2);
    checkOutput("t4_err_sticky", 32'(err_full), 1);

    // start while busy is ignored; stop together with the limit hit
    rx_q.delete();
    n_hits = 2;
    word_src = 32'h0BADBEEF;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_err_clear", 32'(err_full), 0);
    checkOutput("t5_wc_clear", 32'(word_count), 0);
    n_hits = 1;
    applyStimulus(1, 0, 1, 0);
    checkOutput("t5_restart_ignored", 32'(tdc_enable), 1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t5_en_collide", 32'(tdc_enable), 0);
    checkOutput("t5_busy_collide", 32'(busy), 1);
    waitIdle("t5", 100);
    checkOutput("t5_len", 32'(rx_q.size()), 2 * PKT_LEN);
    checkPacket("t5_p0", 0, 32'h0BADBEEF);
    checkPacket("t5_p1", PKT_LEN, 32'h0BADBEEF);
    checkOutput("t5_wc", 32'(word_count), 2);

    // Reset in the middle of a packet
    rx_q.delete();
    n_hits = 1;
    word_src = 32'h12345678;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    n = 0;
    while (!(tx_valid === 1'b1 && tx_data === 8'h56) && n < 30) begin tick(); n++; end
    checkOutput("t6_reach_b2", 32'(tx_data), 32'h56);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_en", 32'(tdc_enable), 0);
    checkOutput("t6_rd", 32'(fifo_rd_en), 0);
    checkOutput("t6_valid", 32'(tx_valid), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_data", 32'(tx_data), 0);
    checkOutput("t6_wc", 32'(word_count), 0);
    vio = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) vio++;
    end
    checkOutput("t6_quiet", 32'(vio), 0);
    checkOutput("t6_bytes", 32'(rx_q.size()), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
